// File: rtl/wib_pkg.sv
// Shared types and constants for the WIB ping-pong buffer.
// Optional parity storage is selected by the WIB_PARITY_EN macro.
package wib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } wib_state_e;

    localparam int HOST_DW = 32;

    localparam logic [2:0] SRAM_EMA   = 3'b010;
    localparam logic [1:0] SRAM_EMAW  = 2'b00;
    localparam logic       SRAM_RET1N = 1'b1;

`ifdef WIB_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // Expand 4 byte enables into a 32-bit per-bit enable vector.
    function automatic logic [31:0] be_to_bits(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/rfsp_wrapper.sv
// Single-port register-file SRAM with bit-write mask (active-low controls).
module rfsp_wrapper #(
    parameter int W  = 19,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          gwen,
    input  logic [W-1:0]  wen,
    input  logic [AW-1:0] a,
    input  logic [W-1:0]  d,
    input  logic [2:0]    ema,
    input  logic [1:0]    emaw,
    input  logic          ret1n,
    output logic [W-1:0]  q
);

    logic [W-1:0] mem [2**AW];
    logic [W-1:0] q_q;
    logic         unused_cfg;

    assign unused_cfg = ^{ema, emaw};
    assign q = q_q;

    always_ff @(posedge clk) begin
        if (!cen && ret1n) begin
            if (!gwen) begin
                mem[a] <= (mem[a] & wen) | (d & ~wen);
            end else begin
                q_q <= mem[a];
            end
        end
    end

endmodule

// File: rtl/wib_bank.sv
// One buffer bank: steers either the NPU or the host port onto its SRAM.
// With WIB_PARITY_EN the extra word bit holds even parity of the data.
module wib_bank
    import wib_pkg::*;
#(
    parameter int DW = 19,
    parameter int AW = 10,
    parameter int RW = DW + PAR_W
) (
    input  logic          i_clk,
    input  logic          i_npu_sel,
    input  logic          i_npu_en,
    input  logic [AW-1:0] i_npu_addr,
    input  logic          i_host_en,
    input  logic          i_host_we,
    input  logic [3:0]    i_host_be,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_wdata,
    output logic [RW-1:0] o_q
);

    logic [31:0]   be_bits;
    logic          ram_cen;
    logic          ram_gwen;
    logic [AW-1:0] ram_addr;
    logic [RW-1:0] ram_d;
    logic [RW-1:0] ram_wen;
    logic          unused_be;

    assign unused_be = ^be_bits;

    always_comb begin
        be_bits          = be_to_bits(i_host_be);
        ram_d            = '0;
        ram_wen          = '1;
        ram_d[DW-1:0]    = i_host_wdata;
        ram_wen[DW-1:0]  = ~be_bits[DW-1:0];
`ifdef WIB_PARITY_EN
        // Parity only follows a write that covers every data byte.
        ram_d[DW]        = ^i_host_wdata;
        ram_wen[DW]      = ~(&be_bits[DW-1:0]);
`endif
        ram_cen          = 1'b1;
        ram_gwen         = 1'b1;
        ram_addr         = i_npu_addr;
        if (i_npu_sel) begin
            ram_cen  = ~i_npu_en;
        end else begin
            ram_cen  = ~i_host_en;
            ram_gwen = ~i_host_we;
            ram_addr = i_host_addr;
        end
    end

    rfsp_wrapper #(
        .W  (RW),
        .AW (AW)
    ) u_ram (
        .clk   (i_clk),
        .cen   (ram_cen),
        .gwen  (ram_gwen),
        .wen   (ram_wen),
        .a     (ram_addr),
        .d     (ram_d),
        .ema   (SRAM_EMA),
        .emaw  (SRAM_EMAW),
        .ret1n (SRAM_RET1N),
        .q     (o_q)
    );

endmodule

// File: rtl/wib_pingpong_buffer.sv
// Ping-pong weight buffer: NPU reads one bank while the host fills the other.
// Build with WIB_PARITY_EN to store and check a per-word parity bit.
//
//   state    | meaning
//   ST_IDLE  | host accesses accepted, waiting for a swap request
//   ST_DRAIN | host blocked, waiting for NPU/host reads to finish
//   ST_SWAP  | banks exchanged this cycle, o_swap_ack high
module wib_pingpong_buffer
    import wib_pkg::*;
#(
    parameter int DW      = 19,
    parameter int AW      = 10,
    parameter bit REG_OUT = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_rd_en,
    input  logic [AW-1:0]      i_raddr,
    output logic [DW-1:0]      o_rdat,
    output logic               o_rdat_vld,
    output logic               o_rd_perr,
    input  logic               i_host_en,
    input  logic               i_host_we,
    input  logic [3:0]         i_host_be,
    input  logic [AW-1:0]      i_host_addr,
    input  logic [HOST_DW-1:0] i_host_wdata,
    output logic [HOST_DW-1:0] o_host_rdata,
    output logic               o_host_rvld,
    output logic               o_host_ready,
    input  logic               i_swap_req,
    output logic               o_swap_ack,
    output logic               o_rd_bank
);

    localparam int RW = DW + PAR_W;

    wib_state_e    state_q, state_d;
    logic          rd_bank_q, rd_bank_d;
    logic          rd_p1_q, rd_p1_d;
    logic          rd_sel_q, rd_sel_d;
    logic          host_p1_q, host_p1_d;
    logic          host_sel_q, host_sel_d;
    logic          host_acc, host_rd_acc;
    logic          npu_busy, host_busy;
    logic [RW-1:0] q0, q1, rd_word, host_word;
    logic          perr_raw;
    logic [DW-1:0] host_dat;
    logic          unused_hbits;

    assign o_host_ready = (state_q == ST_IDLE);
    assign o_swap_ack   = (state_q == ST_SWAP);
    assign o_rd_bank    = rd_bank_q;
    assign host_acc     = i_host_en & o_host_ready;
    assign host_rd_acc  = host_acc & ~i_host_we;
    assign rd_word      = rd_sel_q ? q1 : q0;
    assign host_word    = host_sel_q ? q1 : q0;
    assign unused_hbits = ^{i_host_wdata, host_word};

    // A read counts as in flight until its data reaches the output pins.
    assign npu_busy  = REG_OUT ? rd_p1_q : 1'b0;
    assign host_busy = REG_OUT ? host_p1_q : 1'b0;

`ifdef WIB_PARITY_EN
    assign perr_raw = ^rd_word;
`else
    assign perr_raw = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rd_bank_d  = rd_bank_q;
        rd_p1_d    = i_rd_en;
        rd_sel_d   = i_rd_en ? rd_bank_q : rd_sel_q;
        host_p1_d  = host_rd_acc;
        host_sel_d = host_rd_acc ? ~rd_bank_q : host_sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_swap_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!i_rd_en && !npu_busy && !host_busy) begin
                    state_d   = ST_SWAP;
                    rd_bank_d = ~rd_bank_q;
                end
            end
            ST_SWAP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            rd_bank_q  <= 1'b0;
            rd_p1_q    <= 1'b0;
            rd_sel_q   <= 1'b0;
            host_p1_q  <= 1'b0;
            host_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_bank_q  <= rd_bank_d;
            rd_p1_q    <= rd_p1_d;
            rd_sel_q   <= rd_sel_d;
            host_p1_q  <= host_p1_d;
            host_sel_q <= host_sel_d;
        end
    end

    wib_bank #(.DW(DW), .AW(AW), .RW(RW)) u_bank0 (
        .i_clk        (i_clk),
        .i_npu_sel    (~rd_bank_q),
        .i_npu_en     (i_rd_en),
        .i_npu_addr   (i_raddr),
        .i_host_en    (host_acc),
        .i_host_we    (i_host_we),
        .i_host_be    (i_host_be),
        .i_host_addr  (i_host_addr),
        .i_host_wdata (i_host_wdata[DW-1:0]),
        .o_q          (q0)
    );

    wib_bank #(.DW(DW), .AW(AW), .RW(RW)) u_bank1 (
        .i_clk        (i_clk),
        .i_npu_sel    (rd_bank_q),
        .i_npu_en     (i_rd_en),
        .i_npu_addr   (i_raddr),
        .i_host_en    (host_acc),
        .i_host_we    (i_host_we),
        .i_host_be    (i_host_be),
        .i_host_addr  (i_host_addr),
        .i_host_wdata (i_host_wdata[DW-1:0]),
        .o_q          (q1)
    );

    if (REG_OUT) begin : g_reg
        logic [DW-1:0] rdat_q, rdat_d, hrdat_q, hrdat_d;
        logic          rvld_q, perr_q, hvld_q;

        always_comb begin
            rdat_d  = rd_p1_q ? rd_word[DW-1:0] : rdat_q;
            hrdat_d = host_p1_q ? host_word[DW-1:0] : hrdat_q;
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rdat_q  <= '0;
                rvld_q  <= 1'b0;
                perr_q  <= 1'b0;
                hrdat_q <= '0;
                hvld_q  <= 1'b0;
            end else begin
                rdat_q  <= rdat_d;
                rvld_q  <= rd_p1_q;
                perr_q  <= rd_p1_q & perr_raw;
                hrdat_q <= hrdat_d;
                hvld_q  <= host_p1_q;
            end
        end

        assign o_rdat      = rdat_q;
        assign o_rdat_vld  = rvld_q;
        assign o_rd_perr   = perr_q;
        assign host_dat    = hrdat_q;
        assign o_host_rvld = hvld_q;
    end else begin : g_comb
        // SRAM Q holds between reads; the seen flags hide it until first use.
        logic rd_seen_q, rd_seen_d, host_seen_q, host_seen_d;

        always_comb begin
            rd_seen_d   = rd_seen_q | i_rd_en;
            host_seen_d = host_seen_q | host_rd_acc;
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rd_seen_q   <= 1'b0;
                host_seen_q <= 1'b0;
            end else begin
                rd_seen_q   <= rd_seen_d;
                host_seen_q <= host_seen_d;
            end
        end

        assign o_rdat      = rd_seen_q ? rd_word[DW-1:0] : '0;
        assign o_rdat_vld  = rd_p1_q;
        assign o_rd_perr   = rd_p1_q & perr_raw;
        assign host_dat    = host_seen_q ? host_word[DW-1:0] : '0;
        assign o_host_rvld = host_p1_q;
    end

    always_comb begin
        o_host_rdata           = '0;
        o_host_rdata[DW-1:0]   = host_dat;
    end

endmodule
